// File: rtl/iir_pkg.sv
// Shared definitions for the first-order IIR section.
// Purpose : word widths, fixed-point format, saturation bounds and the
//           scale-and-clamp helper used by the filter datapath.
// Contents: N_BITS / FRAC / ACC_BITS, sample_t / prod_t / acc_t,
//           SAT_MAX / SAT_MIN, function sat_scale().
package iir_pkg;

  localparam int N_BITS   = 32;
  localparam int FRAC     = 16;
  // Three full-width products plus the aligned offset need two guard bits.
  localparam int ACC_BITS = 2 * N_BITS + 2;

  typedef logic signed [N_BITS-1:0]   sample_t;
  typedef logic signed [2*N_BITS-1:0] prod_t;
  typedef logic signed [ACC_BITS-1:0] acc_t;

  localparam sample_t SAT_MAX = {1'b0, {(N_BITS-1){1'b1}}};
  localparam sample_t SAT_MIN = {1'b1, {(N_BITS-1){1'b0}}};

  // Drop FRAC fractional bits (floor, via arithmetic shift) and clamp the
  // result into the sample range so the output never wraps.
  function automatic sample_t sat_scale(input acc_t acc);
    acc_t w_sh;
    w_sh = acc >>> FRAC;
    if (w_sh > acc_t'(SAT_MAX)) begin
      return SAT_MAX;
    end else if (w_sh < acc_t'(SAT_MIN)) begin
      return SAT_MIN;
    end else begin
      return sample_t'(w_sh);
    end
  endfunction

endpackage : iir_pkg

// File: rtl/iir_if.sv
// Sample/coefficient bundle between the controller/sample source and the
// IIR section.
// Signals : x_i (sample), b0_i, b1_i, a_i (coefficients), offset_i,
//           y_o (filtered result back from the filter).
// Modports: master - source/controller side, drives samples and coefficients
//           slave  - filter side, consumes them and returns y_o
interface iir_if;
  import iir_pkg::*;

  sample_t x_i;
  sample_t b0_i;
  sample_t b1_i;
  sample_t a_i;
  sample_t offset_i;
  sample_t y_o;

  modport master (
    output x_i,
    output b0_i,
    output b1_i,
    output a_i,
    output offset_i,
    input  y_o
  );

  modport slave (
    input  x_i,
    input  b0_i,
    input  b1_i,
    input  a_i,
    input  offset_i,
    output y_o
  );

endinterface : iir_if

// File: rtl/q16_mul.sv
// Signed full-precision multiplier for Q16.16 operands.
// Ports: i_a, i_b - signed N_BITS operands
//        o_p      - signed 2*N_BITS product (Q32.32), purely combinational
module q16_mul
  import iir_pkg::*;
(
  input  sample_t i_a,
  input  sample_t i_b,
  output prod_t   o_p
);

  // Sign-extend both operands first so the product is exact at full width.
  assign o_p = prod_t'(i_a) * prod_t'(i_b);

endmodule : q16_mul

// File: rtl/iir_filter.sv
// First-order direct-form-I IIR section, one Q16.16 sample per clock:
//   y[n] = sat((b0*x[n] + b1*x[n-1] + a*y[n-1] + (offset<<16)) >>> 16)
// The feedback coefficient is added, so a decaying pole is stored as its
// negation by the controller.
// Ports: clk    - rising-edge clock
//        rst_ni - asynchronous active-low reset, clears x[n-1] and y
//        bus    - iir_if.slave: x_i, b0_i, b1_i, a_i, offset_i in; y_o out
//                 (y_o is registered, one cycle after x_i is captured)
module iir_filter
  import iir_pkg::*;
(
  input  logic clk,
  input  logic rst_ni,
  iir_if.slave bus
);

  sample_t r_x_d;
  sample_t r_y;

  prod_t   w_p_b0;
  prod_t   w_p_b1;
  prod_t   w_p_a;
  acc_t    w_acc;
  sample_t w_y_next;

  q16_mul u_mul_b0 (
    .i_a (bus.b0_i),
    .i_b (bus.x_i),
    .o_p (w_p_b0)
  );

  q16_mul u_mul_b1 (
    .i_a (bus.b1_i),
    .i_b (r_x_d),
    .o_p (w_p_b1)
  );

  // Feedback uses the already-saturated output, so a clamp is held, not wrapped.
  q16_mul u_mul_a (
    .i_a (bus.a_i),
    .i_b (r_y),
    .o_p (w_p_a)
  );

  // Adder tree at Q34.32; offset is aligned to the product binary point.
  always_comb begin
    w_acc    = acc_t'(w_p_b0) + acc_t'(w_p_b1) + acc_t'(w_p_a)
             + (acc_t'(bus.offset_i) <<< FRAC);
    w_y_next = sat_scale(w_acc);
  end

  // Sample history and output registers; reset discards all history.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_x_d <= '0;
      r_y   <= '0;
    end else begin
      r_x_d <= bus.x_i;
      r_y   <= w_y_next;
    end
  end

  assign bus.y_o = r_y;

endmodule : iir_filter

// File: tb/tb_iir_filter.sv
// Self-checking bench for iir_filter: directed vectors with hand-computed
// expected outputs, pushed into a scoreboard queue by the driver and popped
// by an independent monitor one cycle later.
module tb_iir_filter;

  logic clk;
  logic rst_ni;

  iir_if u_if ();

  iir_filter u_dut (
    .clk    (clk),
    .rst_ni (rst_ni),
    .bus    (u_if.slave)
  );

  typedef struct {
    logic [31:0] exp;
    bit          chk;
    string       name;
  } sb_ent_t;

  sb_ent_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] HALF = 32'h0000_8000;
  localparam logic [31:0] MAXV = 32'h7FFF_FFFF;
  localparam logic [31:0] MINV = 32'h8000_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_coef(input logic [31:0] b0, input logic [31:0] b1,
                          input logic [31:0] a, input logic [31:0] off);
    u_if.b0_i     = b0;
    u_if.b1_i     = b1;
    u_if.a_i      = a;
    u_if.offset_i = off;
  endtask

  // Called at a falling edge: drive x, queue the result expected after the
  // next rising edge, then advance to the following falling edge.
  task automatic step(input logic [31:0] x, input logic [31:0] exp,
                      input bit chk, input string name);
    sb_ent_t e;
    u_if.x_i = x;
    e.exp  = exp;
    e.chk  = chk;
    e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one output per rising edge while entries are pending.
  initial begin
    sb_ent_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        if (e.chk) check(e.name, u_if.y_o, e.exp);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0;
    u_if.x_i = ONE;
    set_coef(ONE, ONE, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("reset_y", u_if.y_o, 32'h0);
    rst_ni = 1'b1;

    // Impulse; first sample proves x[n-1] was cleared despite x=1.0 in reset.
    step(ONE,   ONE,   1'b1, "imp0");
    step(32'h0, ONE,   1'b1, "imp1");
    step(32'h0, 32'h0, 1'b1, "imp2");

    // Step response with a=0.5: 1.0, 1.5, 1.75, 1.875, 1.9375 ...
    set_coef(ONE, 32'h0, HALF, 32'h0);
    step(ONE, 32'h0001_0000, 1'b1, "step1");
    step(ONE, 32'h0001_8000, 1'b1, "step2");
    step(ONE, 32'h0001_C000, 1'b1, "step3");
    step(ONE, 32'h0001_E000, 1'b1, "step4");
    step(ONE, 32'h0001_F000, 1'b1, "step5");
    for (int i = 0; i < 15; i++) step(ONE, 32'h0, 1'b0, "step_run");
    // Floor truncation parks the output one LSB below 2.0.
    step(ONE, 32'h0001_FFFF, 1'b1, "step_settle");

    // Negative data; x[n-1] is still 1.0 on the first cycle.
    set_coef(ONE, ONE, 32'h0, 32'h0);
    step(32'h0,         ONE,           1'b1, "neg_flush");
    step(32'hFFEB_0000, 32'hFFEB_0000, 1'b1, "neg_first");
    step(32'hFFEB_0000, 32'hFFD6_0000, 1'b1, "neg_held");

    // Saturation at both rails.
    set_coef(MAXV, MAXV, 32'h0, 32'h0);
    step(MAXV, MAXV,          1'b1, "sat_pos0");
    step(MAXV, MAXV,          1'b1, "sat_pos1");
    step(MINV, 32'hFFFF_8000, 1'b1, "sat_mixed");
    step(MINV, MINV,          1'b1, "sat_neg");

    // Feedback of the clamped value must stay clamped.
    set_coef(32'h0, 32'h0, ONE, 32'hFFFF_0000);
    step(32'h0, MINV, 1'b1, "fb_hold_off");
    set_coef(32'h0, 32'h0, MAXV, 32'h0);
    step(32'h0, MINV, 1'b1, "fb_hold_big");

    // Zero coefficients: output is the offset regardless of x.
    set_coef(32'h0, 32'h0, 32'h0, 32'h0000_4000);
    step(32'h1234_5678, 32'h0000_4000, 1'b1, "offset0");
    step(32'h8765_4321, 32'h0000_4000, 1'b1, "offset1");

    // Asynchronous reset between edges clears the output immediately.
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_reset_y", u_if.y_o, 32'h0);
    check("sb_drain", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_iir_filter
